// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the MIPS32 multiply/divide unit:
//   - mdu_op_t    : MULT / MULTU / DIV / DIVU op field encodings
//   - mdu_state_t : IDLE / RUN / FIX sequencer states
//   - DIV0_LO     : LO value produced by a divide by zero
//   - op_is_signed: true for the two signed ops (MULT, DIV)
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the iterative multiply/divide datapath.
// The accumulator is a 2*WIDTH pair {upper, lower}.
//   multiply: lower holds the remaining multiplier bits; if its LSB is set the
//             multiplicand (i_operand) is added to upper, then the whole pair
//             shifts right by one.
//   divide  : lower holds the remaining dividend bits; the pair shifts left by
//             one and the divisor (i_operand) is trial-subtracted from upper.
//             The quotient bit is returned on o_qbit; o_acc leaves bit 0 clear
//             so the caller merges the quotient bit in.
// Ports:
//   i_mode    in  1        0 = multiply step, 1 = divide step
//   i_acc     in  2*WIDTH  current accumulator pair
//   i_operand in  WIDTH    multiplicand / divisor magnitude
//   o_acc     out 2*WIDTH  next accumulator pair
//   o_qbit    out 1        quotient bit (divide only, 0 for multiply)
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_mode,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qbit
);

    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_addend = i_acc[0] ? {1'b0, i_operand} : '0;
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;
        // Upper half shifted left with the next dividend bit pulled in.
        w_shift  = i_acc[2*WIDTH-1:WIDTH-1];
        w_trial  = w_shift - {1'b0, i_operand};
        o_qbit   = 1'b0;
        o_acc    = '0;
        if (i_mode) begin
            // Trial result non-negative means the divisor fits.
            o_qbit = ~w_trial[WIDTH];
            o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                      i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are latched on an accepted start, converted to magnitudes for the
// signed ops, processed one bit per cycle for WIDTH cycles, and the signs are
// applied in FIX when HI/LO are written. MTHI/MTLO writes land only while idle.
// Optional build macro: MDU_EARLY_OUT_EN -- skip the iterations when the divisor
// or a multiply operand is zero (done arrives 3 cycles after launch).
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset (aborts any op)
//   start    in  1      launch op (accepted only when not busy)
//   op       in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  in  WIDTH  multiplicand / dividend
//   rt_data  in  WIDTH  multiplier / divisor
//   hi_we    in  1      MTHI write enable
//   lo_we    in  1      MTLO write enable
//   mt_data  in  WIDTH  MTHI/MTLO data
//   busy     out 1      operation in flight
//   done     out 1      one-cycle pulse, HI/LO hold the new result
//   hi, lo   out WIDTH  HI / LO registers
// -----------------------------------------------------------------------------
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   mt_data,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int                 CW    = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT1  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2  = (2*WIDTH)'(1);

    mdu_state_t          r_state;
    logic [CW-1:0]       r_count;
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_div0;
    logic                r_zero_mul;
    logic                r_done;
    logic [WIDTH-1:0]    r_operand;
    logic [WIDTH-1:0]    r_rs_raw;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [2*WIDTH-1:0]  r_acc;

    // Launch-time magnitude conversion.
    logic                w_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [WIDTH-1:0]    w_rs_mag;
    logic [WIDTH-1:0]    w_rt_mag;

    always_comb begin
        w_signed = op_is_signed(op);
        w_rs_neg = w_signed & rs_data[WIDTH-1];
        w_rt_neg = w_signed & rt_data[WIDTH-1];
        w_rs_mag = w_rs_neg ? (~rs_data + ONE) : rs_data;
        w_rt_mag = w_rt_neg ? (~rt_data + ONE) : rt_data;
    end

    logic [2*WIDTH-1:0]  w_step_acc;
    logic                w_step_qbit;
    logic [2*WIDTH-1:0]  w_next_acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_qbit    (w_step_qbit)
    );

    // The quotient bit enters the pair at its LSB.
    assign w_next_acc = w_step_acc | {{(2*WIDTH-1){1'b0}}, w_step_qbit};

    // Sign fix-up and special cases applied when HI/LO are written.
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_quot;
    logic [WIDTH-1:0]    w_rem;
    logic [WIDTH-1:0]    w_fix_hi;
    logic [WIDTH-1:0]    w_fix_lo;

    always_comb begin
        // A zero operand may have skipped the iterations; force the product.
        w_prod = r_zero_mul ? '0 : r_acc;
        if (r_neg_res) w_prod = ~w_prod + ONE2;
        w_quot = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];
        if (r_neg_res) w_quot = ~w_quot + ONE;
        if (r_neg_rem) w_rem  = ~w_rem + ONE;
        if (!r_is_div) begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end else if (r_div0) begin
            w_fix_hi = r_rs_raw;
            w_fix_lo = WIDTH'(DIV0_LO);
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
            r_zero_mul <= 1'b0;
            r_done     <= 1'b0;
            r_operand  <= '0;
            r_rs_raw   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // start takes priority over a same-cycle MT write.
                        r_is_div   <= op[1];
                        r_neg_res  <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem  <= op[1] & w_rs_neg;
                        r_div0     <= (rt_data == '0);
                        r_zero_mul <= ~op[1] & ((rs_data == '0) | (rt_data == '0));
                        r_rs_raw   <= rs_data;
                        r_operand  <= op[1] ? w_rt_mag : w_rs_mag;
                        r_acc      <= {{WIDTH{1'b0}}, (op[1] ? w_rs_mag : w_rt_mag)};
                        r_count    <= '0;
                        r_state    <= RUN;
                    end else begin
                        if (hi_we) r_hi <= mt_data;
                        if (lo_we) r_lo <= mt_data;
                    end
                end
                RUN: begin
                    r_acc   <= w_next_acc;
                    r_count <= r_count + CNT1;
                    if (r_count == LAST) r_state <= FIX;
`ifdef MDU_EARLY_OUT_EN
                    if ((r_count == '0) && (r_is_div ? r_div0 : r_zero_mul))
                        r_state <= FIX;
`endif
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv
// Scoreboard bench for mips_muldiv: each launched op pushes its expected
// {hi,lo} and a monitor pops and compares on every done pulse. Latency and
// busy duration are checked per op; MT writes, ignored starts and a reset
// abort are exercised at the end.
// -----------------------------------------------------------------------------
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: return sa * sb;
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 3;
`endif
        return 34;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst !== 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_result"}, {hi, lo}, {e.hi, e.lo});
                $display("op %s: hi=%h lo=%h", e.tag, hi, lo);
            end
        end
    end

    // Called at a negedge; launches an op and tracks latency/busy until done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int lat, busy_cnt, want;
        e.tag = tag; e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        want = exp_lat(o, a, b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk);
        lat = 0; busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(want));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(want - 1));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] m;
        int ndone;

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; mt_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);

        // Directed ops, back-to-back (each launch in the done cycle of the previous).
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",   2'b00, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_zero",  2'b11, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        run_op("div_neg_rt", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_zero",   2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("mult_zero",  2'b00, 32'd0,         32'hFFFF_FFFB, 32'h0,         32'h0);

        // Random ops against the arithmetic model (no zero divisor / overflow).
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom | 32'h1;
            if (ro == 2'b10 && ra == 32'h8000_0000) ra = 32'h7FFF_0000;
            m = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, m[63:32], m[31:0]);
        end

        // MTHI then MTLO while idle.
        hi_we = 1'b1; mt_data = 32'hCAFE_BABE;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; mt_data = 32'h1357_9BDF;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", {32'd0, hi}, {32'd0, 32'hCAFE_BABE});
        check("mtlo", {32'd0, lo}, {32'd0, 32'h1357_9BDF});
        $display("mt: hi=%h lo=%h", hi, lo);

        // start with a same-cycle MTHI, then a second start + MTHI while busy.
        begin
            exp_t e;
            e.tag = "divu_ign"; e.hi = 32'd2; e.lo = 32'd14;
            sb_q.push_back(e);
        end
        start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
        hi_we = 1'b1; mt_data = 32'hFFFF_0000;
        @(posedge clk);
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; hi_we = 1'b0;
                check("mt_vs_start", {32'd0, hi}, {32'd0, 32'hCAFE_BABE});
            end
            if (k == 5) begin
                start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd3;
                hi_we = 1'b1; mt_data = 32'h1111_1111;
            end
            if (k == 6) begin
                start = 1'b0; hi_we = 1'b0;
                check("mt_busy_dropped", {32'd0, hi}, {32'd0, 32'hCAFE_BABE});
            end
            if (done === 1'b1) begin
                ndone = k;
                break;
            end
        end
        check("ign_latency", 64'(ndone), 64'd34);
        repeat (40) @(negedge clk);
        check("ign_idle_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of an op: abort, HI/LO cleared, no done.
        hi_we = 1'b1; mt_data = 32'hCAFE_BABE;
        @(negedge clk);
        hi_we = 1'b0;
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd5;
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        rst = 1'b0;
        check("abort_hi",   {32'd0, hi}, 64'd0);
        check("abort_lo",   {32'd0, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        $display("abort: hi=%h lo=%h busy=%b", hi, lo, busy);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
